// File: rtl/div_issue_ctrl_pkg.sv
// Shared definitions for the divide issue controller: FSM encodings,
// the divide-by-zero quotient and the result payload layout.
package div_issue_ctrl_pkg;

    localparam int unsigned TAG_W_DEF = 6;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LAUNCH = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_DONE0  = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    localparam logic [31:0] DIVZERO_Q = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } div_res_t;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Bus between the issue controller (master) and the iterative divider (slave).
interface div_issue_ctrl_if;

    logic [31:0] dv_a;
    logic [31:0] dv_b;
    logic        dv_signed;
    logic        dv_start;
    logic        dv_flush;
    logic        dv_busy;
    logic        dv_done;
    logic [31:0] dv_q;
    logic [31:0] dv_rem;

    modport master (
        output dv_a, dv_b, dv_signed, dv_start, dv_flush,
        input  dv_busy, dv_done, dv_q, dv_rem
    );

    modport slave (
        input  dv_a, dv_b, dv_signed, dv_start, dv_flush,
        output dv_busy, dv_done, dv_q, dv_rem
    );

endinterface

// File: rtl/div_issue_ctrl_out_buf.sv
// One-entry valid/ready register slice; accepts a new entry in the cycle
// the current one drains, and a flush empties it.
module div_out_buf #(
    parameter int unsigned W = 70
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         flush,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic         can_load,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign can_load = ~out_valid | out_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load && can_load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issues one DIV/DIVU at a time to the iterative divider, resolves divide by
// zero locally, and returns {tag, HI=rem, LO=q} through a one-entry buffer.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int unsigned TAG_W        = TAG_W_DEF,
    parameter logic        DIVZERO_FAST = 1'b1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_a,
    input  logic [31:0]        in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    div_issue_ctrl_if.master   dv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TAG_W-1:0]   out_tag,
    output logic [31:0]        out_hi,
    output logic [31:0]        out_lo
);

    logic [2:0]       state, state_d;
    logic [31:0]      a_q, b_q;
    logic             sgn_q;
    logic [TAG_W-1:0] tag_q;
    div_res_t         res_q;
    logic             squash;

    logic             buf_can_load;
    logic             accept;
    logic             capture;
    logic [TAG_W+63:0] buf_dout;

    assign in_ready = (state == ST_IDLE) & buf_can_load & ~flush;
    assign accept   = in_valid & in_ready;
    assign capture  = (state == ST_WAIT) & dv.dv_done & ~squash;

    // Operands always come from the latched copy so they stay stable for the whole divide.
    assign dv.dv_a      = a_q;
    assign dv.dv_b      = b_q;
    assign dv.dv_signed = sgn_q;
    assign dv.dv_start  = (state == ST_LAUNCH) & ~dv.dv_busy & ~flush;
    assign dv.dv_flush  = flush;

    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE:   if (accept) state_d = (DIVZERO_FAST && in_b == '0) ? ST_DONE0 : ST_LAUNCH;
            ST_LAUNCH: if (!dv.dv_busy) state_d = ST_WAIT;
            ST_WAIT:   if (capture) state_d = ST_RESP;
            ST_DONE0:  state_d = ST_RESP;
            ST_RESP:   if (buf_can_load) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            sgn_q  <= 1'b0;
            tag_q  <= '0;
            res_q  <= '0;
            squash <= 1'b0;
        end else begin
            state  <= state_d;
            // A flush on the divider's final iteration can still yield one done pulse.
            squash <= flush & (state == ST_WAIT);
            if (accept) begin
                a_q   <= in_a;
                b_q   <= in_b;
                sgn_q <= in_signed;
                tag_q <= in_tag;
            end
            if (capture) begin
                res_q.hi <= dv.dv_rem;
                res_q.lo <= dv.dv_q;
            end else if (state == ST_DONE0) begin
                res_q.hi <= a_q;
                res_q.lo <= DIVZERO_Q;
            end
        end
    end

    div_out_buf #(
        .W(TAG_W + 64)
    ) u_out_buf (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .load      ((state == ST_RESP) & ~flush),
        .load_data ({tag_q, res_q.hi, res_q.lo}),
        .can_load  (buf_can_load),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (buf_dout)
    );

    assign out_tag = buf_dout[TAG_W+63:64];
    assign out_hi  = buf_dout[63:32];
    assign out_lo  = buf_dout[31:0];

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl with a behavioural iterative divider
// on the slave side of the divider bus.
module tb_div_issue_ctrl;

    localparam int TW = 6;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_signed = 1'b0;
    logic          out_ready = 1'b0;
    logic [31:0]   in_a = '0;
    logic [31:0]   in_b = '0;
    logic [TW-1:0] in_tag = '0;
    logic          in_ready;
    logic          out_valid;
    logic [TW-1:0] out_tag;
    logic [31:0]   out_hi;
    logic [31:0]   out_lo;

    div_issue_ctrl_if dv();

    div_issue_ctrl #(
        .TAG_W(TW),
        .DIVZERO_FAST(1'b1)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .in_tag    (in_tag),
        .dv        (dv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_tag   (out_tag),
        .out_hi    (out_hi),
        .out_lo    (out_lo)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int start_cnt = 0;
    bit rand_rdy = 1'b0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural divider ----------------
    logic        m_busy = 1'b0, m_done = 1'b0, m_s = 1'b0;
    logic [31:0] m_a = '0, m_b = '0, m_q = '0, m_r = '0;
    int          m_cnt = 0;

    assign dv.dv_busy = m_busy;
    assign dv.dv_done = m_done;
    assign dv.dv_q    = m_q;
    assign dv.dv_rem  = m_r;

    function automatic int div_iters(input logic [31:0] a, input logic s);
        logic [31:0] mag;
        mag = (s && a[31]) ? (~a + 32'd1) : a;
        if (mag < 32'd16) return 4;
        if (mag < 32'd256) return 8;
        if (mag < 32'd65536) return 16;
        return 32;
    endfunction

    function automatic logic [63:0] div_calc(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
        return {a % b, a / b};
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 0; m_q <= '0; m_r <= '0;
        end else begin
            m_done <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
            if (dv.dv_flush) begin
                m_busy <= 1'b0;
                m_cnt  <= 0;
                // flush landing on the last iteration still produces one done
                if (m_busy && m_cnt == 1) begin
                    m_done <= 1'b1;
                    {m_r, m_q} <= div_calc(m_a, m_b, m_s);
                end
            end else if (m_busy) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    {m_r, m_q} <= div_calc(m_a, m_b, m_s);
                end
            end else if (dv.dv_start) begin
                m_busy <= 1'b1;
                m_cnt  <= div_iters(dv.dv_a, dv.dv_signed);
                m_a    <= dv.dv_a;
                m_b    <= dv.dv_b;
                m_s    <= dv.dv_signed;
            end
        end
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        logic [TW-1:0] tag;
        logic [31:0]   hi;
        logic [31:0]   lo;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b,
                                       input logic s, input logic [TW-1:0] t);
        exp_t e;
        int   sa, sd;
        e.tag = t;
        if (b == 32'd0) begin
            e.lo = 32'hFFFF_FFFF;
            e.hi = a;
        end else if (s) begin
            sa = a;
            sd = b;
            e.lo = sa / sd;
            e.hi = sa % sd;
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
        return e;
    endfunction

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t          e;
        bit            hold = 1'b0;
        logic [TW-1:0] h_tag;
        logic [31:0]   h_hi, h_lo;
        forever begin
            @(negedge clk);
            #2;
            if (resetn) begin
                if (dv.dv_start) begin
                    start_cnt++;
                    chk("start_while_busy", 96'(m_busy), 96'(0));
                end
                if (m_busy) chk("dv_operand_hold", 96'({dv.dv_a, dv.dv_b}), 96'({m_a, m_b}));
                if (hold) begin
                    chk("hold_valid", 96'(out_valid), 96'(1));
                    chk("hold_data", 96'({out_tag, out_hi, out_lo}), 96'({h_tag, h_hi, h_lo}));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_result: got tag %0h hi %0h lo %0h, none expected",
                                 out_tag, out_hi, out_lo);
                    end else begin
                        e = sb.pop_front();
                        chk("result_tag", 96'(out_tag), 96'(e.tag));
                        chk("result_hi", 96'(out_hi), 96'(e.hi));
                        chk("result_lo", 96'(out_lo), 96'(e.lo));
                    end
                end
                hold  = out_valid && !out_ready;
                h_tag = out_tag;
                h_hi  = out_hi;
                h_lo  = out_lo;
            end else begin
                hold = 1'b0;
            end
        end
    end

    initial begin : ready_driver
        forever begin
            @(negedge clk);
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [TW-1:0] t, output bit drained);
        int w = 0;
        drained = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_signed = s; in_tag = t;
        #1;
        while (!in_ready && w < 500) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1 within 500 cycles");
            in_valid = 1'b0;
            return;
        end
        drained = out_valid && out_ready;
        sb.push_back(ref_model(a, b, s, t));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while ((sb.size() != 0 || out_valid) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0 || out_valid) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: pending got %0d expected 0", sb.size());
        end
    endtask

    initial begin : watchdog
        #3_000_000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin : stim
        bit   dr;
        int   s0, w;
        exp_t dummy;
        logic [31:0] ra, rb;
        logic        rs;

        repeat (2) @(negedge clk);
        #1;
        chk("reset_in_ready", 96'(in_ready), 96'(1));
        chk("reset_out_valid", 96'(out_valid), 96'(0));
        chk("reset_dv_start", 96'(dv.dv_start), 96'(0));
        chk("reset_dv_flush", 96'(dv.dv_flush), 96'(0));
        @(negedge clk);
        resetn = 1'b1;

        // DIVU 100/7
        out_ready = 1'b1;
        s0 = start_cnt;
        send(32'd100, 32'd7, 1'b0, 6'd3, dr);
        wait_drain();
        chk("divu_start_once", 96'(start_cnt - s0), 96'(1));

        // DIV -7/2
        send(32'hFFFF_FFF9, 32'd2, 1'b1, 6'd5, dr);
        wait_drain();

        // DIVU 5/0 resolved locally, two cycles to out_valid
        s0 = start_cnt;
        send(32'd5, 32'd0, 1'b0, 6'd7, dr);
        @(negedge clk); #2 chk("divzero_lat_c1", 96'(out_valid), 96'(0));
        @(negedge clk); #2 chk("divzero_lat_c2", 96'(out_valid), 96'(0));
        @(negedge clk); #2 chk("divzero_lat_c3", 96'(out_valid), 96'(1));
        wait_drain();
        chk("divzero_no_start", 96'(start_cnt - s0), 96'(0));

        // backpressure with a second op accepted only in the drain cycle
        out_ready = 1'b0;
        send(32'd50, 32'd5, 1'b0, 6'd9, dr);
        w = 0;
        while (!out_valid && w < 200) begin @(negedge clk); w++; end
        chk("bp_result_seen", 96'(out_valid), 96'(1));
        fork
            begin
                send(32'd81, 32'd9, 1'b0, 6'd10, dr);
                chk("bp_accept_on_drain", 96'(dr), 96'(1));
            end
            begin
                repeat (10) begin
                    @(negedge clk);
                    #1 chk("bp_in_ready_low", 96'(in_ready), 96'(0));
                end
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // flush on the divider's final iteration, stray done must be ignored
        send(32'h1234_5678, 32'd3, 1'b0, 6'd11, dr);
        w = 0;
        while (!(m_busy && m_cnt == 1) && w < 200) begin @(negedge clk); w++; end
        chk("flush_reached_last_iter", 96'(m_cnt), 96'(1));
        flush = 1'b1;
        dummy = sb.pop_back();
        @(negedge clk);
        flush = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #2 chk("flush_no_result", 96'(out_valid), 96'(0));
        end
        send(32'd9, 32'd3, 1'b0, 6'd12, dr);
        wait_drain();

        // asynchronous reset during WAIT
        send(32'hFFFF_0000, 32'd7, 1'b0, 6'd13, dr);
        w = 0;
        while (!m_busy && w < 50) begin @(negedge clk); w++; end
        repeat (3) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("rst_mid_out_valid", 96'(out_valid), 96'(0));
        chk("rst_mid_in_ready", 96'(in_ready), 96'(1));
        sb.delete();
        @(negedge clk);
        resetn = 1'b1;
        repeat (50) begin
            @(negedge clk);
            #2 chk("rst_no_spurious", 96'(out_valid), 96'(0));
        end

        // randomized traffic with random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0: ra = $urandom_range(0, 15);
                1: ra = $urandom_range(0, 255);
                2: ra = $urandom_range(0, 65535);
                default: ra = $urandom;
            endcase
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : 32'($urandom);
            if (rb == 32'd0 && $urandom_range(0, 7) != 0) rb = 32'd1;
            rs = 1'($urandom_range(0, 1));
            if (rs && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd2;
            send(ra, rb, rs, 6'(i), dr);
        end
        rand_rdy = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        wait_drain();
        chk("final_queue_empty", 96'(sb.size()), 96'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Sits between the issue queue and the iterative divider; accepts one DIV/DIVU micro-op at a time through a valid/ready handshake.
- Launches the divider, holds its operands stable, and captures quotient/remainder in the divider's single-cycle done pulse.
- Returns {tag, HI=rem, LO=q} to writeback through a one-entry output buffer with backpressure.
- Handles divide-by-zero locally and squashes everything on flush from Commit.

Parameters:
TAG_W, 6, width of the ROB tag carried with each op
DIVZERO_FAST, 1, 1 = resolve B==0 in this block without launching the divider

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
flush  in  1  from Commit; kills the in-flight op and the output buffer
in_valid  in  1  op available from issue
in_ready  out  1  block can accept an op this cycle
in_a  in  32  dividend (rs)
in_b  in  32  divisor (rt)
in_signed  in  1  1 = DIV, 0 = DIVU
in_tag  in  TAG_W  ROB tag
dv_a  out  32  divider operand A
dv_b  out  32  divider operand B
dv_signed  out  1  divider signed_en
dv_start  out  1  divider start
dv_flush  out  1  divider flush
dv_busy  in  1  divider busy
dv_done  in  1  divider done pulse
dv_q  in  32  divider quotient
dv_rem  in  32  divider remainder
out_valid  out  1  result available
out_ready  in  1  writeback accepts
out_tag  out  TAG_W  tag of result
out_hi  out  32  remainder
out_lo  out  32  quotient

Behaviour:
- Reset: FSM=IDLE; in_ready=1; out_valid=0; dv_start=0; dv_flush=0; all data registers 0; squash=0.
- FSM states:
  - IDLE: in_ready = ~out_valid | out_ready. On in_valid & in_ready, latch a, b, signed, tag.
    - If DIVZERO_FAST and in_b==0: go to DONE0.
    - Otherwise go to LAUNCH.
  - LAUNCH: dv_start=1; dv_a/dv_b/dv_signed driven from the latched registers, never from in_*. The divider samples operands on this same edge. Go to WAIT. Lasts exactly 1 cycle.
  - WAIT: dv_a/dv_b/dv_signed held. On dv_done & ~squash, capture dv_q→lo and dv_rem→hi in that same cycle (the divider zeroes q on the following idle cycle), then go to RESP.
  - DONE0: lo=32'hFFFF_FFFF; hi=latched a. Go to RESP. Total in→out latency 2 cycles.
  - RESP: load the output buffer when it is empty or being drained; out_valid=1. Go to IDLE.
- Output buffer:
  - out_valid holds until out_valid & out_ready.
  - A new result may load in the same cycle the old one drains.
  - out_tag, out_hi, out_lo are stable while out_valid=1 & ~out_ready.
- Latency with the divider: accept → LAUNCH +1 → dv_done after N+1 cycles, where N ∈ {4, 8, 16, 32} is chosen by the divider from operand magnitude → RESP +1 → out_valid the next cycle.
- Only one op in flight. in_ready=0 in LAUNCH, WAIT, DONE0 and RESP.
- Flush:
  - Combinational dv_flush=flush.
  - Next edge: FSM=IDLE, out_valid=0, latched op discarded.
  - If flush occurs in WAIT, squash=1 for exactly the next cycle. Any dv_done in that cycle is ignored, because the divider can still pulse done once after a flush landing on its final iteration.
  - flush with simultaneous in_valid: the op is not accepted (in_ready forced 0 while flush=1).
- dv_start is never asserted while dv_busy=1. If dv_busy=1 in LAUNCH (not expected), stay in LAUNCH with dv_start=0 until dv_busy=0.
- Arithmetic: this block does no sign handling; it passes signed to the divider. Signed INT_MIN/−1 yields the divider's natural result, passed through unchanged.
- Reset mid-operation: async clear of all state. No done is expected afterwards; the divider resets too.

Decomposition:
- Shared package/defs: FSM state encodings (IDLE, LAUNCH, WAIT, DONE0, RESP); DIVZERO_Q constant 32'hFFFF_FFFF; default TAG_W.
- One natural sub-module: div_out_buf, a one-entry valid/ready register slice holding {tag, hi, lo}.

Test Plan:
- DIVU 100/7, tag 3, out_ready=1 → one out_valid pulse, out_tag=3, out_lo=14, out_hi=2; dv_start high exactly 1 cycle.
- DIV −7/2 (in_a=32'hFFFF_FFF9) → out_lo=32'hFFFF_FFFD (−3), out_hi=32'hFFFF_FFFF (−1).
- DIVU 5/0, DIVZERO_FAST=1 → dv_start never asserted; out_lo=32'hFFFF_FFFF, out_hi=5; out_valid 2 cycles after accept.
- Backpressure: out_ready=0 for 10 cycles after the result → out_valid/out_tag/out_hi/out_lo stable; in_ready=0; a second op is accepted only in the drain cycle.
- Flush in WAIT on the divider's last iteration (DIVU 0x12345678/3) → out_valid stays 0; the following dv_done is ignored; the next op 9/3 returns lo=3, hi=0.
- resetn deasserted during WAIT → out_valid=0, in_ready=1 immediately (asynchronous); no spurious result after reset release.
